// File: rtl/uart_tx_arbiter.sv
// Four-port round-robin packet arbiter feeding a single UART TX byte stream.
// A granted port keeps the stream until its last byte or an idle-stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned IDLE_TIMEOUT   = 65535,
  parameter int unsigned PORT_ID_INSERT = 0
) (
  input  logic        clock_sig,
  input  logic        reset_sig,
  input  logic        clk_ena,
  input  logic [3:0]  in_valid,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_last,
  output logic [3:0]  in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [3:0]  grant,
  output logic        timeout
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(IDLE_TIMEOUT);
  localparam bit          TIMEOUT_EN    = (IDLE_TIMEOUT != 0);
  localparam bit          HEADER_EN     = (PORT_ID_INSERT != 0);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PASS
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [15:0] stall_q, stall_d;
  logic        timeout_q, timeout_d;

  logic        sel_found;
  logic [1:0]  sel_idx;
  logic [1:0]  cand;
  logic        g_valid;
  logic        g_last;
  logic [7:0]  g_data;

  // Round-robin search starting one past the previous owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (!sel_found && in_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    g_valid = in_valid[gidx_q];
    g_last  = in_last[gidx_q];
    g_data  = in_data[{gidx_q, 3'b000} +: 8];
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    in_ready  = '0;
    case (state_q)
      HEADER: begin
        out_valid = 1'b1;
        out_data  = {4'hF, 2'b00, gidx_q};
      end
      PASS: begin
        out_valid = g_valid;
        out_data  = g_data;
        in_ready  = grant_q & {4{out_ready}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    gidx_d       = gidx_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    stall_d      = stall_q;
    timeout_d    = 1'b0;
    if (clk_ena) begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            state_d = HEADER_EN ? HEADER : PASS;
            gidx_d  = sel_idx;
            grant_d = 4'b0001 << sel_idx;
            stall_d = '0;
          end
        end
        HEADER: begin
          if (out_ready) begin
            state_d = PASS;
            stall_d = '0;
          end
        end
        PASS: begin
          // A byte transfer wins over the stall path, so a last byte never times out.
          if (g_valid && out_ready) begin
            stall_d = '0;
            if (g_last) begin
              state_d      = IDLE;
              grant_d      = '0;
              last_grant_d = gidx_q;
            end
          end else if (!g_valid) begin
            stall_d = stall_q + 16'd1;
            if (TIMEOUT_EN && (stall_d == TIMEOUT_LIMIT)) begin
              state_d      = IDLE;
              grant_d      = '0;
              last_grant_d = gidx_q;
              stall_d      = '0;
              timeout_d    = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q      <= IDLE;
      gidx_q       <= '0;
      grant_q      <= '0;
      last_grant_q <= '1;
      stall_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
      timeout_q    <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level model checked every cycle on the main
// instance, plus directed literal checks on a header-inserting instance.
module tb_uart_tx_arbiter;

  localparam int TB_TO = 8;

  logic        clock_sig = 1'b0;
  logic        reset_sig = 1'b1;
  logic        clk_ena   = 1'b1;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  grant;
  logic        timeout;

  logic [3:0]  b_valid;
  logic [31:0] b_data;
  logic [3:0]  b_last;
  logic [3:0]  b_ready;
  logic        b_ordy;
  logic        b_ov;
  logic [7:0]  b_od;
  logic [3:0]  b_grant;
  logic        b_to;

  uart_tx_arbiter #(.IDLE_TIMEOUT(8), .PORT_ID_INSERT(0)) dut (
    .clock_sig(clock_sig), .reset_sig(reset_sig), .clk_ena(clk_ena),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .grant(grant), .timeout(timeout)
  );

  uart_tx_arbiter #(.IDLE_TIMEOUT(0), .PORT_ID_INSERT(1)) dut_hdr (
    .clock_sig(clock_sig), .reset_sig(reset_sig), .clk_ena(1'b1),
    .in_valid(b_valid), .in_data(b_data), .in_last(b_last), .in_ready(b_ready),
    .out_ready(b_ordy), .out_valid(b_ov), .out_data(b_od),
    .grant(b_grant), .timeout(b_to)
  );

  always #5 clock_sig = ~clock_sig;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: owner -1 means nobody holds the stream.
  int         m_owner = -1;
  int         m_last  = 3;
  int         m_stall = 0;
  bit         m_to    = 1'b0;

  logic [7:0] got[$];
  int         byte_cyc[$];
  int         glog[$];
  int         cyc       = 0;
  int         to_count  = 0;
  int         to_cyc    = 0;
  logic [3:0] prev_grant = '0;
  logic [3:0] fire       = '0;
  logic [8:0] srcq [4][$];
  bit         toggle = 1'b0;

  function automatic int oh_idx(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  always @(negedge clock_sig) begin
    logic       e_valid;
    logic [7:0] e_data;
    logic [3:0] e_ready;
    logic [3:0] e_grant;
    bit         found;
    int         nxt;
    cyc++;
    if (reset_sig) begin
      m_owner = -1; m_last = 3; m_stall = 0; m_to = 1'b0;
    end
    e_valid = 1'b0; e_data = '0; e_ready = '0; e_grant = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_valid          = in_valid[m_owner];
      e_data           = in_data[8*m_owner +: 8];
      e_ready[m_owner] = out_ready;
    end
    chk("m_grant", 32'(grant), 32'(e_grant));
    chk("m_out_valid", 32'(out_valid), 32'(e_valid));
    chk("m_out_data", 32'(out_data), 32'(e_data));
    chk("m_in_ready", 32'(in_ready), 32'(e_ready));
    chk("m_timeout", 32'(timeout), 32'(m_to));

    fire = e_ready & in_valid & {4{clk_ena & ~reset_sig}};
    if (e_valid && out_ready && clk_ena && !reset_sig) begin
      got.push_back(out_data);
      byte_cyc.push_back(cyc);
    end
    if (grant != 0 && prev_grant == 0) glog.push_back(oh_idx(grant));
    prev_grant = grant;
    if (timeout) begin
      to_count++;
      to_cyc = cyc;
    end

    m_to = 1'b0;
    if (!reset_sig && clk_ena) begin
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          nxt = (m_last + k) % 4;
          if (!found && in_valid[nxt]) begin
            found = 1'b1; m_owner = nxt; m_stall = 0;
          end
        end
      end else if (in_valid[m_owner] && out_ready) begin
        m_stall = 0;
        if (in_last[m_owner]) begin
          m_last = m_owner; m_owner = -1;
        end
      end else if (!in_valid[m_owner]) begin
        m_stall++;
        if (TB_TO > 0 && m_stall == TB_TO) begin
          m_last = m_owner; m_owner = -1; m_stall = 0; m_to = 1'b1;
        end
      end
    end
  end

  task automatic present();
    logic [8:0] h;
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() > 0) begin
        h = srcq[i][0];
        in_valid[i] = 1'b1; in_data[8*i +: 8] = h[7:0]; in_last[i] = h[8];
      end else begin
        in_valid[i] = 1'b0; in_data[8*i +: 8] = '0; in_last[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clock_sig);
    #1;
    for (int i = 0; i < 4; i++)
      if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    present();
    if (toggle) clk_ena = ~clk_ena;
  endtask

  task automatic push(input int p, input logic [7:0] d, input bit l);
    srcq[p].push_back({l, d});
    present();
  endtask

  task automatic clr();
    got.delete(); byte_cyc.delete(); glog.delete(); to_count = 0;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) srcq[i].delete();
    present();
  endtask

  task automatic do_reset();
    reset_sig = 1'b1;
    flush();
    step(); step();
    reset_sig = 1'b0;
    clr();
  endtask

  task automatic chk_byte(input int k, input logic [7:0] v);
    if (got.size() > k) chk($sformatf("byte%0d", k), 32'(got[k]), 32'(v));
    else begin
      checks++; failures++;
      $display("FAIL byte%0d: missing, expected %0h", k, v);
    end
  endtask

  task automatic chk_g(input int k, input int v);
    if (glog.size() > k) chk($sformatf("grant_seq%0d", k), glog[k], v);
    else begin
      checks++; failures++;
      $display("FAIL grant_seq%0d: missing, expected %0d", k, v);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int b = budget;
    while (got.size() < n && b > 0) begin step(); b--; end
    chk("wait_bytes", 32'(got.size() >= n), 32'd1);
  endtask

  task automatic wait_to(input int n, input int budget);
    int b = budget;
    while (to_count < n && b > 0) begin step(); b--; end
    chk("wait_timeout", 32'(to_count >= n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
    b_valid = '0; b_data = '0; b_last = '0; b_ordy = 1'b1;
    #3;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_b_grant", 32'(b_grant), 32'h0);
    step(); step();
    reset_sig = 1'b0;
    clr();

    // Two simultaneous 3-byte packets on ports 0 and 2.
    push(0, 8'h11, 0); push(0, 8'h12, 0); push(0, 8'h13, 1);
    push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 1);
    repeat (20) step();
    chk("s1_nbytes", got.size(), 6);
    chk_byte(0, 8'h11); chk_byte(1, 8'h12); chk_byte(2, 8'h13);
    chk_byte(3, 8'h21); chk_byte(4, 8'h22); chk_byte(5, 8'h23);
    chk("s1_ngrants", glog.size(), 2);
    chk_g(0, 0); chk_g(1, 2);

    // All ports continuously offering single-byte packets.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) push(i, 8'(32'hA0 + 16*i + k), 1);
    repeat (25) step();
    chk("s2_nbytes", got.size(), 8);
    for (int j = 0; j < 8; j++) begin
      chk_byte(j, 8'(32'hA0 + 16*(j%4) + j/4));
      chk_g(j, j % 4);
    end
    if (byte_cyc.size() == 8)
      for (int j = 1; j < 8; j++) chk($sformatf("s2_gap%0d", j), byte_cyc[j] - byte_cyc[j-1], 2);

    // Downstream backpressure longer than the timeout must not release the lock.
    do_reset();
    push(1, 8'h31, 0); push(1, 8'h32, 0); push(1, 8'h33, 0); push(1, 8'h34, 1);
    wait_bytes(2, 20);
    out_ready = 1'b0;
    repeat (10) step();
    chk("s3_bp_nbytes", got.size(), 2);
    chk("s3_bp_grant", 32'(grant), 32'h2);
    chk("s3_bp_tocount", to_count, 0);
    out_ready = 1'b1;
    repeat (10) step();
    chk("s3_nbytes", got.size(), 4);
    chk_byte(0, 8'h31); chk_byte(1, 8'h32); chk_byte(2, 8'h33); chk_byte(3, 8'h34);
    chk("s3_tocount", to_count, 0);

    // Port 3 stalls without last; lock released by timeout, then port 0 ahead of port 3.
    do_reset();
    push(2, 8'h40, 1); push(3, 8'h7E, 0);
    wait_to(1, 60);
    if (byte_cyc.size() == 2) chk("s4_to_delay", to_cyc - byte_cyc[1], 9);
    else chk("s4_pre_nbytes", got.size(), 2);
    chk("s4_grant_idle", 32'(grant), 32'h0);
    chk("s4_pulse_one", 32'(timeout), 32'h0);
    push(0, 8'h01, 1); push(3, 8'h7F, 1);
    repeat (10) step();
    chk_byte(0, 8'h40); chk_byte(1, 8'h7E); chk_byte(2, 8'h01); chk_byte(3, 8'h7F);
    chk_g(0, 2); chk_g(1, 3); chk_g(2, 0); chk_g(3, 3);
    chk("s4_tocount", to_count, 1);

    // Same stall with clk_ena alternating: only enabled clocks count.
    do_reset();
    push(3, 8'h7E, 0);
    toggle = 1'b1;
    wait_to(1, 80);
    toggle = 1'b0;
    clk_ena = 1'b1;
    if (byte_cyc.size() == 1) chk("s4b_to_delay", to_cyc - byte_cyc[0], 17);
    else chk("s4b_nbytes", got.size(), 1);
    chk("s4b_grant_idle", 32'(grant), 32'h0);
    chk("s4b_tocount", to_count, 1);

    // Reset in the middle of a port 2 packet after port 1 was served.
    do_reset();
    push(1, 8'h91, 1);
    wait_bytes(1, 20);
    push(2, 8'h61, 0); push(2, 8'h62, 0); push(2, 8'h63, 1);
    wait_bytes(2, 20);
    chk("s5_mid_grant", 32'(grant), 32'h4);
    chk("s5_mid_valid", 32'(out_valid), 32'h1);
    reset_sig = 1'b1;
    #1;
    chk("s5_rst_grant", 32'(grant), 32'h0);
    chk("s5_rst_out_valid", 32'(out_valid), 32'h0);
    chk("s5_rst_out_data", 32'(out_data), 32'h0);
    chk("s5_rst_in_ready", 32'(in_ready), 32'h0);
    chk("s5_rst_timeout", 32'(timeout), 32'h0);
    flush();
    step();
    push(0, 8'h81, 1); push(1, 8'h82, 1); push(2, 8'h83, 1);
    step();
    reset_sig = 1'b0;
    clr();
    repeat (15) step();
    chk_g(0, 0); chk_g(1, 1); chk_g(2, 2);
    chk_byte(0, 8'h81); chk_byte(1, 8'h82); chk_byte(2, 8'h83);

    // Header-inserting instance: port 1 single byte 0x55.
    b_valid = 4'b0010; b_data = 32'h0000_5500; b_last = 4'b0010;
    step();
    chk("b_hdr_grant", 32'(b_grant), 32'h2);
    chk("b_hdr_valid", 32'(b_ov), 32'h1);
    chk("b_hdr_data", 32'(b_od), 32'hF1);
    chk("b_hdr_ready", 32'(b_ready), 32'h0);
    step();
    chk("b_pass_data", 32'(b_od), 32'h55);
    chk("b_pass_valid", 32'(b_ov), 32'h1);
    chk("b_pass_ready", 32'(b_ready), 32'h2);
    step();
    b_valid = '0; b_last = '0;
    chk("b_done_grant", 32'(b_grant), 32'h0);
    chk("b_done_valid", 32'(b_ov), 32'h0);
    chk("b_done_data", 32'(b_od), 32'h0);

    // Header held under backpressure; timeout disabled on this instance.
    b_valid = 4'b0001; b_data = 32'h0000_00AA;
    step();
    chk("b2_grant", 32'(b_grant), 32'h1);
    chk("b2_hdr_data", 32'(b_od), 32'hF0);
    b_ordy = 1'b0;
    step();
    chk("b2_hdr_hold", 32'(b_od), 32'hF0);
    chk("b2_hdr_ready", 32'(b_ready), 32'h0);
    b_ordy = 1'b1;
    step();
    chk("b2_pass_data", 32'(b_od), 32'hAA);
    chk("b2_pass_ready", 32'(b_ready), 32'h1);
    step();
    b_valid = '0;
    for (int n = 0; n < 20; n++) begin
      step();
      chk("b2_no_timeout", 32'(b_to), 32'h0);
      chk("b2_lock_kept", 32'(b_grant), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
